// File: rtl/everloop_pkg.sv
// Shared definitions for the everloop LED transmitter and sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package everloop_pkg;

   // Transmitter state encoding
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2,
      S_DONE = 2'd3
   } tx_state_e;

   // Default WS2812 bit timings in ns, shared with the sequencer
   localparam int T0H_NS_DEF  = 350;
   localparam int T1H_NS_DEF  = 700;
   localparam int TBIT_NS_DEF = 1250;
   localparam int DATA_W_DEF  = 16;

   // Convert a duration in ns to whole clock cycles (truncating)
   function automatic int cyc(input longint freq_hz, input int ns);
      longint mhz;
      mhz = freq_hz / 64'd1_000_000;
      return int'((mhz * longint'(ns)) / 64'd1000);
   endfunction

endpackage

// File: rtl/everloop_bit_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Latency: a load of value V makes tc rise V cycles later.
// Backpressure: none; load overrides the running count.
module everloop_bit_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: load wins, otherwise count down and park at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/everloop_ws2812_tx.sv
// Serialises one DATA_W word MSB-first onto a WS2812 line, pulses send_complete when done.
// Latency: data_valid in cycle N -> line high in N+1; word takes DATA_W*TBIT_C + 1 cycles.
// Backpressure: strobes while busy or in the done cycle are dropped (flagged on overrun
// when EVERLOOP_TX_OVERRUN_EN is defined); reset_everloop aborts to idle.
module everloop_ws2812_tx
   import everloop_pkg::*;
#(
   parameter int SYS_FREQ_HZ = 100_000_000,
   parameter int T0H_NS      = T0H_NS_DEF,
   parameter int T1H_NS      = T1H_NS_DEF,
   parameter int TBIT_NS     = TBIT_NS_DEF,
   parameter int DATA_W      = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              data_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic              reset_everloop,
   output logic              everloop_ctl,
   output logic              send_complete,
   output logic              busy
`ifdef EVERLOOP_TX_OVERRUN_EN
   ,
   output logic              overrun
`endif
);

   localparam int T0H_C  = cyc(longint'(SYS_FREQ_HZ), T0H_NS);
   localparam int T1H_C  = cyc(longint'(SYS_FREQ_HZ), T1H_NS);
   localparam int TBIT_C = cyc(longint'(SYS_FREQ_HZ), TBIT_NS);
   localparam int CNT_W  = $clog2(TBIT_C + 1);
   localparam int BIDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   // Phase lengths as timer load values (timer counts load_val+1 cycles)
   localparam logic [CNT_W-1:0] LD_H0 = CNT_W'(T0H_C - 1);
   localparam logic [CNT_W-1:0] LD_H1 = CNT_W'(T1H_C - 1);
   localparam logic [CNT_W-1:0] LD_L0 = CNT_W'(TBIT_C - T0H_C - 1);
   localparam logic [CNT_W-1:0] LD_L1 = CNT_W'(TBIT_C - T1H_C - 1);

   if (T0H_C < 1) begin : g_bad_t0h
      $error("everloop_ws2812_tx: T0H_C must be at least 1 cycle");
   end
   if (T1H_C <= T0H_C) begin : g_bad_t1h
      $error("everloop_ws2812_tx: T1H_C must exceed T0H_C");
   end
   if (TBIT_C <= T1H_C) begin : g_bad_tbit
      $error("everloop_ws2812_tx: TBIT_C must exceed T1H_C");
   end

   tx_state_e          state_q, state_d;
   logic [DATA_W-1:0]  shift_q, shift_d;
   logic [BIDX_W-1:0]  bit_idx_q, bit_idx_d;
   logic               everloop_ctl_q, everloop_ctl_d;
   logic               send_complete_q, send_complete_d;
   logic               busy_q, busy_d;

   logic               tmr_load;
   logic [CNT_W-1:0]   tmr_val;
   logic               tmr_tc;

   everloop_bit_timer #(
      .CNT_W (CNT_W)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (resetn),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      tmr_load  = 1'b0;
      tmr_val   = '0;

      if (reset_everloop) begin
         // Latch-gap request aborts any word and drops a coincident strobe
         state_d   = S_IDLE;
         shift_d   = '0;
         bit_idx_d = '0;
         tmr_load  = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (data_valid) begin
                  state_d   = S_HIGH;
                  shift_d   = data_in;
                  bit_idx_d = BIDX_W'(DATA_W - 1);
                  tmr_load  = 1'b1;
                  tmr_val   = data_in[DATA_W-1] ? LD_H1 : LD_H0;
               end
            end
            S_HIGH: begin
               if (tmr_tc) begin
                  state_d  = S_LOW;
                  tmr_load = 1'b1;
                  tmr_val  = shift_q[DATA_W-1] ? LD_L1 : LD_L0;
               end
            end
            S_LOW: begin
               if (tmr_tc) begin
                  if (bit_idx_q == '0) begin
                     state_d = S_DONE;
                  end else begin
                     state_d   = S_HIGH;
                     bit_idx_d = bit_idx_q - 1'b1;
                     shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                     tmr_load  = 1'b1;
                     tmr_val   = shift_q[DATA_W-2] ? LD_H1 : LD_H0;
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // Outputs follow the next state so they are registered yet cycle-accurate
      everloop_ctl_d  = (state_d == S_HIGH);
      busy_d          = (state_d == S_HIGH) || (state_d == S_LOW);
      send_complete_d = (state_d == S_DONE);
   end

   // State, datapath and output registers
   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q         <= S_IDLE;
         shift_q         <= '0;
         bit_idx_q       <= '0;
         everloop_ctl_q  <= 1'b0;
         send_complete_q <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         shift_q         <= shift_d;
         bit_idx_q       <= bit_idx_d;
         everloop_ctl_q  <= everloop_ctl_d;
         send_complete_q <= send_complete_d;
         busy_q          <= busy_d;
      end
   end

   assign everloop_ctl  = everloop_ctl_q;
   assign send_complete = send_complete_q;
   assign busy          = busy_q;

`ifdef EVERLOOP_TX_OVERRUN_EN
   logic overrun_q, overrun_d;
   logic rst_evl_q, rst_evl_d;

   // Sticky flag for strobes that arrive while a word is in flight or finishing
   always_comb begin
      overrun_d = overrun_q;
      rst_evl_d = reset_everloop;
      if (reset_everloop && !rst_evl_q) begin
         overrun_d = 1'b0;
      end else if (data_valid && (state_q != S_IDLE)) begin
         overrun_d = 1'b1;
      end
   end

   // Overrun flag and reset_everloop edge-detect registers
   always_ff @(posedge clk) begin
      if (resetn) begin
         overrun_q <= 1'b0;
         rst_evl_q <= 1'b0;
      end else begin
         overrun_q <= overrun_d;
         rst_evl_q <= rst_evl_d;
      end
   end

   assign overrun = overrun_q;
`endif

endmodule

// File: doc/everloop_ws2812_tx.md
Name: everloop_ws2812_tx

Overview:
- Bit-level transmitter and responder for the everloop LED sequencer's read/complete handshake.
- Accepts one 16-bit LED data word per strobe from the everloop RAM read path and serialises it MSB-first onto the WS2812-style single-wire LED line.
- Returns a one-cycle send_complete pulse when the word is finished.
- Holds the line low while the sequencer requests the inter-frame latch gap.

Parameters:
- SYS_FREQ_HZ, "mandatory", system clock frequency in Hz.
- T0H_NS, 350, high time of a '0' bit in ns.
- T1H_NS, 700, high time of a '1' bit in ns.
- TBIT_NS, 1250, total bit period in ns.
- DATA_W, 16, width of one data word.

Ports:
- clk  input  1  system clock.
- resetn  input  1  one clock; reset is synchronous and active-high. The codebase port name is kept despite the polarity.
- data_valid  input  1  one-cycle strobe; data_in is valid in this cycle.
- data_in  input  DATA_W  LED word, transmitted MSB first.
- reset_everloop  input  1  latch-gap request from the sequencer. While high, the line is held low.
- everloop_ctl  output  1  serial LED line.
- send_complete  output  1  one-cycle pulse after the last bit's low phase ends.
- busy  output  1  high from acceptance of a word until send_complete.

Behaviour:
- Timing constants: CYC(ns) = (SYS_FREQ_HZ/1_000_000 * ns)/1000, with integer truncation.
  - This gives T0H_C, T1H_C and TBIT_C.
  - Elaboration error if T0H_C < 1, T1H_C <= T0H_C, or TBIT_C <= T1H_C.
- Reset: state=S_IDLE; everloop_ctl, send_complete, busy = 0; shift register and counters = 0.
- States:
  - S_IDLE: line low, busy=0.
    - data_valid=1 and reset_everloop=0 -> latch data_in, bit_idx=DATA_W-1, phase counter=0, go to S_HIGH.
  - S_HIGH: line high, busy=1.
    - Stay for T1H_C cycles if the current bit is 1, else T0H_C cycles; then go to S_LOW with the counter cleared.
  - S_LOW: line low, busy=1.
    - Stay until the total bit time is TBIT_C cycles, i.e. TBIT_C−THx cycles.
    - If bit_idx==0, go to S_DONE. Otherwise decrement bit_idx, shift left, and go to S_HIGH.
  - S_DONE: send_complete=1 for exactly one cycle, busy=0, line low, then go to S_IDLE.
- Latency:
  - data_valid in cycle N -> everloop_ctl high in cycle N+1.
  - A word occupies DATA_W*TBIT_C cycles plus one S_DONE cycle.
- All outputs are registered; no combinational path runs from inputs to outputs.
- Boundary conditions:
  - data_valid while busy (any non-IDLE state): ignored. The word in flight is unaffected.
  - data_valid in the S_DONE cycle: ignored.
  - reset_everloop high in any state: abort to S_IDLE next cycle. The line goes low with no send_complete, and the shift register is cleared.
  - reset_everloop together with data_valid: reset_everloop wins and the word is dropped.
  - resetn mid-word: all state returns to its reset value on the next edge. The line is low.
  - All-zero and all-one words use the same bit period; there is no inter-word gap beyond S_DONE plus the upstream re-read latency.

Optional Feature:
- Macro EVERLOOP_TX_OVERRUN_EN.
- When defined:
  - Adds output port overrun (1 bit).
  - overrun is set sticky when data_valid arrives while busy=1 or in S_DONE.
  - It clears on resetn or on the rising edge of reset_everloop.
  - Reset value 0.
- When undefined: the port and its logic are absent, and ignored strobes are silently dropped.

Decomposition:
- Package everloop_pkg:
  - State encoding localparams S_IDLE/S_HIGH/S_LOW/S_DONE.
  - The CYC() constant function.
  - Default ns timing constants shared with the sequencer.
- Sub-module everloop_bit_timer:
  - Loadable down-counter with a terminal-count flag.
  - The transmitter instantiates it once to time both the high and low phases.

Test Plan:
- SYS_FREQ_HZ=100_000_000 (T0H_C=35, T1H_C=70, TBIT_C=125); data_valid with data_in=16'hA5F0.
  -> 16 bit periods of 125 cycles; high widths 70,35,70,35,35,70,35,70,70,70,70,70,35,35,35,35.
  -> send_complete pulse 2000 cycles after the line first rises.
- Handshake loop with the sequencer model (N_LEDS=2, 4 words).
  -> exactly 4 send_complete pulses, then a reset_everloop gap; the line stays low throughout the gap.
- data_valid re-asserted at bit 5 of a word.
  -> the first word completes unchanged with one send_complete.
  -> with EVERLOOP_TX_OVERRUN_EN, overrun=1 until the next reset_everloop rising edge.
- reset_everloop asserted at bit 9.
  -> everloop_ctl low the next cycle, busy=0, no send_complete; next data_valid starts cleanly.
- resetn asserted for 1 cycle in S_HIGH of a '1' bit.
  -> all outputs 0 the next cycle; no send_complete; the next word transmits correctly.
- data_valid and reset_everloop in the same cycle with data_in=16'hFFFF.
  -> no line activity, busy stays 0.
